// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed seven-segment driver: a free-running double-dabble converter
// feeds committed BCD digits to a scan stage with leading-zero and cursor-blink blanking.
module seven_seg_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] displayValue,
  input  logic [3:0]  curDec,
  input  logic        blinkEnable,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  conv_state_e state_q, state_d;
  logic [35:0] work_q, work_d;
  logic [35:0] adj;
  logic [3:0]  iter_q, iter_d;
  logic        ovf_q, ovf_d;
  logic [15:0] digit_q, digit_d;
  logic        ovf_reg_q, ovf_reg_d;
  logic        valid_q, valid_d;

  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          scan_tick;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] cur_digit;
  logic       upper_zero;
  logic       blank;

  assign dbg_state_o = state_q;

  // Converter: LOAD, 16 add-3/shift cycles, COMMIT; digits only ever change in COMMIT.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    iter_d    = iter_q;
    ovf_d     = ovf_q;
    digit_d   = digit_q;
    ovf_reg_d = ovf_reg_q;
    valid_d   = valid_q;
    adj       = work_q;
    case (state_q)
      ST_LOAD: begin
        work_d  = {20'd0, displayValue};
        ovf_d   = (displayValue > 16'd9999);
        iter_d  = 4'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        for (int k = 0; k < 5; k++) begin
          if (work_q[16+4*k +: 4] >= 4'd5) adj[16+4*k +: 4] = work_q[16+4*k +: 4] + 4'd3;
        end
        work_d = {adj[34:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digit_d   = work_q[31:16];
        ovf_reg_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign scan_tick = (ref_q == RW'(REFRESH_DIV - 1));

  always_comb begin
    ref_d       = scan_tick ? '0 : ref_q + 1'b1;
    idx_d       = scan_tick ? idx_q + 2'd1 : idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (scan_tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output stage looks at the slot currently selected by idx_q; results land one cycle later.
  always_comb begin
    cur_digit  = digit_q[{idx_q, 2'b00} +: 4];
    upper_zero = ((digit_q >> {idx_q, 2'b00}) == 16'd0);
    blank      = !valid_q
               || ((idx_q != 2'd0) && upper_zero && !curDec[idx_q])
               || (blinkEnable && curDec[idx_q] && blink_q);
    an_d       = ~(4'b0001 << idx_q);
    dp_d       = !((idx_q == 2'd3) && ovf_reg_q && valid_q);
    seg_d      = 7'b1111111;
    if (!blank) begin
      case (cur_digit)
        4'd0: seg_d = 7'b1000000;
        4'd1: seg_d = 7'b1111001;
        4'd2: seg_d = 7'b0100100;
        4'd3: seg_d = 7'b0110000;
        4'd4: seg_d = 7'b0011001;
        4'd5: seg_d = 7'b0010010;
        4'd6: seg_d = 7'b0000010;
        4'd7: seg_d = 7'b1111000;
        4'd8: seg_d = 7'b0000000;
        4'd9: seg_d = 7'b0010000;
        default: seg_d = 7'b1111111;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_LOAD;
      work_q      <= '0;
      iter_q      <= '0;
      ovf_q       <= 1'b0;
      digit_q     <= '0;
      ovf_reg_q   <= 1'b0;
      valid_q     <= 1'b0;
      ref_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      iter_q      <= iter_d;
      ovf_q       <= ovf_d;
      digit_q     <= digit_d;
      ovf_reg_q   <= ovf_reg_d;
      valid_q     <= valid_d;
      ref_q       <= ref_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Bench for seven_seg_display_driver: directed scenarios plus random values/cursors,
// checked every cycle against an arithmetic model of what the display should show.
module tb_seven_seg_display_driver;

  localparam int RD = 4;
  localparam int BT = 2;
  localparam logic [11:0] BLANK_OUT = {4'b1111, 7'b1111111, 1'b1};

  logic        CLK;
  logic        RESET;
  logic [15:0] displayValue;
  logic [3:0]  curDec;
  logic        blinkEnable;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic [1:0]  dbg_state;

  seven_seg_display_driver #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .CLK(CLK), .RESET(RESET), .displayValue(displayValue), .curDec(curDec),
    .blinkEnable(blinkEnable), .AN(AN), .SEG(SEG), .DP(DP), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  int  n_checks = 0;
  int  n_errors = 0;
  string cur_tag = "init";

  int  m_edges;
  int  m_sampled;
  int  m_shown;
  bit  m_ovf;
  bit  m_valid;
  bit  m_in_rst;
  int  pow10[4] = '{1, 10, 100, 1000};
  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [11:0] exp_q[$];

  function automatic logic [11:0] model_out();
    int idx, ticks, phase;
    bit bl;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    if (m_in_rst) return BLANK_OUT;
    ticks = m_edges / RD;
    idx   = ticks % 4;
    phase = (ticks / BT) % 2;
    an    = 4'b1111;
    an[idx] = 1'b0;
    seg   = 7'b1111111;
    dp    = 1'b1;
    if (m_valid) begin
      bl = (idx > 0 && (m_shown / pow10[idx]) == 0 && !curDec[idx])
        || (blinkEnable && curDec[idx] && phase == 1);
      if (!bl) seg = seg_tab[(m_shown / pow10[idx]) % 10];
      if (idx == 3 && m_ovf) dp = 1'b0;
    end
    return {an, seg, dp};
  endfunction

  task automatic model_reset();
    m_edges = 0; m_sampled = 0; m_shown = 0; m_ovf = 0; m_valid = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=%b",
               tag, $time, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    int dv;
    exp_q.push_back(model_out());
    dv = int'(displayValue);
    @(posedge CLK);
    if (!m_in_rst) begin
      m_edges++;
      if ((m_edges - 1) % 18 == 0) m_sampled = dv;
      if (m_edges % 18 == 0) begin
        m_shown = m_sampled % 10000;
        m_ovf   = (m_sampled > 9999);
        m_valid = 1;
      end
    end
    #1;
    check(cur_tag, {AN, SEG, DP}, exp_q.pop_front());
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] cd, input logic be);
    displayValue = v;
    curDec       = cd;
    blinkEnable  = be;
  endtask

  task automatic async_reset_pulse(input int hold);
    #2;
    RESET = 1'b0;
    m_in_rst = 1;
    #1;
    check({cur_tag, "_async"}, {AN, SEG, DP}, BLANK_OUT);
    run(hold);
    #2;
    RESET = 1'b1;
    m_in_rst = 0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    RESET = 1'b0;
    m_in_rst = 1;
    model_reset();
    set_inputs(16'd1234, 4'b0001, 1'b0);

    cur_tag = "reset_hold";
    run(3);
    #2;
    RESET = 1'b1;
    m_in_rst = 0;

    cur_tag = "startup_1234";
    run(80);

    cur_tag = "lz_7";
    set_inputs(16'd7, 4'b0001, 1'b0);
    run(56);
    cur_tag = "lz_0_cursor3";
    set_inputs(16'd0, 4'b1000, 1'b0);
    run(56);

    cur_tag = "ovf_65535";
    set_inputs(16'd65535, 4'b0001, 1'b0);
    run(56);
    cur_tag = "ovf_10000";
    set_inputs(16'd10000, 4'b0010, 1'b0);
    run(56);

    cur_tag = "blink_on";
    set_inputs(16'd1234, 4'b0100, 1'b1);
    run(72);
    cur_tag = "blink_off";
    blinkEnable = 1'b0;
    run(40);

    cur_tag = "mid_change";
    set_inputs(16'd1234, 4'b0001, 1'b0);
    while (m_edges % 18 != 5) step();
    displayValue = 16'd4321;
    run(60);

    cur_tag = "mid_reset";
    while (m_edges % 18 != 8) step();
    async_reset_pulse(3);
    cur_tag = "after_reset";
    run(40);

    cur_tag = "random";
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0: v = 16'($urandom_range(0, 9));
        1: v = 16'($urandom_range(0, 999));
        2: v = 16'($urandom_range(9990, 10010));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      set_inputs(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      run($urandom_range(10, 80));
      if ($urandom_range(0, 9) == 0) async_reset_pulse($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
